// File: rtl/filter_sweep_ctrl_pkg.sv
// Shared types and defaults for the filter frequency-sweep sequencer.
package filter_sweep_ctrl_pkg;

  localparam int unsigned SWEEP_RST_CYCLES_DEFAULT = 16;
  localparam int unsigned SWEEP_WORD_WIDTH         = 16;
  localparam int unsigned SWEEP_PERIOD_WIDTH       = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DUT_RST,
    ST_SETTLE,
    ST_MEASURE,
    ST_REPORT,
    ST_NEXT
  } sweep_state_t;

  typedef struct packed {
    logic [SWEEP_PERIOD_WIDTH-1:0] period;
    logic [SWEEP_WORD_WIDTH-1:0]   maximum;
    logic [SWEEP_WORD_WIDTH-1:0]   minimum;
    logic [SWEEP_WORD_WIDTH:0]     p2p;
    logic [SWEEP_PERIOD_WIDTH-1:0] count;
  } sweep_result_t;

endpackage

// File: rtl/filter_sweep_ctrl_if.sv
// Control, sample and result-record signals of the sweep sequencer.
interface filter_sweep_ctrl_if #(
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned PERIOD_WIDTH = 32
);
  logic                           start;
  logic                           abort;
  logic        [PERIOD_WIDTH-1:0] period_start;
  logic        [PERIOD_WIDTH-1:0] period_step;
  logic        [PERIOD_WIDTH-1:0] period_stop;
  logic        [PERIOD_WIDTH-1:0] settle_cycles;
  logic        [PERIOD_WIDTH-1:0] measure_cycles;
  logic        [PERIOD_WIDTH-1:0] period;
  logic                           dut_rst;
  logic signed [WORD_WIDTH-1:0]   sample;
  logic                           sample_valid;
  logic        [PERIOD_WIDTH-1:0] res_period;
  logic signed [WORD_WIDTH-1:0]   res_max;
  logic signed [WORD_WIDTH-1:0]   res_min;
  logic        [WORD_WIDTH:0]     res_p2p;
  logic        [PERIOD_WIDTH-1:0] res_count;
  logic                           res_valid;
  logic                           res_ready;
  logic                           busy;
  logic                           done;

  modport master (
    input  start, abort, period_start, period_step, period_stop,
           settle_cycles, measure_cycles, sample, sample_valid, res_ready,
    output period, dut_rst, res_period, res_max, res_min, res_p2p,
           res_count, res_valid, busy, done
  );

  modport slave (
    output start, abort, period_start, period_step, period_stop,
           settle_cycles, measure_cycles, sample, sample_valid, res_ready,
    input  period, dut_rst, res_period, res_max, res_min, res_p2p,
           res_count, res_valid, busy, done
  );
endinterface

// File: rtl/filter_sweep_ctrl_peak_tracker.sv
// Signed running max/min and valid-sample counter with synchronous clear.
module peak_tracker #(
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic                          i_en,
  input  logic signed [WORD_WIDTH-1:0]  i_sample,
  input  logic                          i_valid,
  output logic signed [WORD_WIDTH-1:0]  o_max,
  output logic signed [WORD_WIDTH-1:0]  o_min,
  output logic        [COUNT_WIDTH-1:0] o_count
);
  localparam logic signed [WORD_WIDTH-1:0] MOST_NEG = {1'b1, {(WORD_WIDTH-1){1'b0}}};
  localparam logic signed [WORD_WIDTH-1:0] MOST_POS = {1'b0, {(WORD_WIDTH-1){1'b1}}};

  logic signed [WORD_WIDTH-1:0]  r_max;
  logic signed [WORD_WIDTH-1:0]  r_min;
  logic        [COUNT_WIDTH-1:0] r_count;

  // Outputs already fold in the current sample so the last window cycle is captured.
  always_comb begin
    o_max   = r_max;
    o_min   = r_min;
    o_count = r_count;
    if (i_en && i_valid) begin
      if (i_sample > r_max) o_max = i_sample;
      if (i_sample < r_min) o_min = i_sample;
      o_count = r_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_max   <= MOST_NEG;
      r_min   <= MOST_POS;
      r_count <= '0;
    end else begin
      r_max   <= o_max;
      r_min   <= o_min;
      r_count <= o_count;
    end
  end
endmodule

// File: rtl/filter_sweep_ctrl.sv
// Frequency-sweep sequencer: steps sine_gen period, resets/settles the DUT and reports output extrema.
module filter_sweep_ctrl
  import filter_sweep_ctrl_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned PERIOD_WIDTH = 32,
  parameter int unsigned RST_CYCLES   = SWEEP_RST_CYCLES_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  filter_sweep_ctrl_if.master bus
);
  sweep_state_t                 r_state;
  sweep_state_t                 w_next;
  logic [PERIOD_WIDTH-1:0]      r_cnt;
  logic [PERIOD_WIDTH-1:0]      r_step;
  logic [PERIOD_WIDTH-1:0]      r_stop;
  logic [PERIOD_WIDTH-1:0]      r_settle;
  logic [PERIOD_WIDTH-1:0]      r_measure;
  logic [PERIOD_WIDTH-1:0]      r_period;
  logic                         r_dut_rst;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_res_valid;
  logic [PERIOD_WIDTH-1:0]      r_res_period;
  logic signed [WORD_WIDTH-1:0] r_res_max;
  logic signed [WORD_WIDTH-1:0] r_res_min;
  logic [WORD_WIDTH:0]          r_res_p2p;
  logic [PERIOD_WIDTH-1:0]      r_res_count;

  logic [PERIOD_WIDTH:0]        w_sum;
  logic                         w_finish;
  logic                         w_cnt_zero;
  logic                         w_clear;
  logic                         w_en;
  logic signed [WORD_WIDTH-1:0] w_trk_max;
  logic signed [WORD_WIDTH-1:0] w_trk_min;
  logic [PERIOD_WIDTH-1:0]      w_trk_count;
  logic [WORD_WIDTH:0]          w_p2p;

  peak_tracker #(
    .WORD_WIDTH  (WORD_WIDTH),
    .COUNT_WIDTH (PERIOD_WIDTH)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_en     (w_en),
    .i_sample (bus.sample),
    .i_valid  (bus.sample_valid),
    .o_max    (w_trk_max),
    .o_min    (w_trk_min),
    .o_count  (w_trk_count)
  );

  always_comb begin
    w_sum      = {1'b0, r_period} + {1'b0, r_step};
    w_finish   = (r_step == '0) || w_sum[PERIOD_WIDTH] || (w_sum[PERIOD_WIDTH-1:0] > r_stop);
    w_cnt_zero = (r_cnt == '0);
    w_p2p      = {w_trk_max[WORD_WIDTH-1], w_trk_max} - {w_trk_min[WORD_WIDTH-1], w_trk_min};

    w_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (bus.start) w_next = ST_DUT_RST;
      ST_DUT_RST: if (w_cnt_zero) w_next = (r_settle == '0) ? ST_MEASURE : ST_SETTLE;
      ST_SETTLE:  if (w_cnt_zero) w_next = ST_MEASURE;
      ST_MEASURE: if (w_cnt_zero) w_next = ST_REPORT;
      ST_REPORT:  if (bus.res_ready) w_next = ST_NEXT;
      ST_NEXT:    w_next = w_finish ? ST_IDLE : ST_DUT_RST;
      default:    w_next = ST_IDLE;
    endcase
    if (bus.abort) w_next = ST_IDLE;

    w_en    = (r_state == ST_MEASURE);
    w_clear = (w_next == ST_MEASURE) && (r_state != ST_MEASURE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_step       <= '0;
      r_stop       <= '0;
      r_settle     <= '0;
      r_measure    <= '0;
      r_period     <= '0;
      r_dut_rst    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_period <= '0;
      r_res_max    <= '0;
      r_res_min    <= '0;
      r_res_p2p    <= '0;
      r_res_count  <= '0;
    end else begin
      r_state     <= w_next;
      r_dut_rst   <= (w_next != ST_IDLE) && (w_next != ST_DUT_RST);
      r_busy      <= (w_next != ST_IDLE);
      r_done      <= (r_state == ST_NEXT) && w_finish && !bus.abort;
      r_res_valid <= (w_next == ST_REPORT);

      // Down-counter reloads on every state entry and expires at zero.
      if (r_state != w_next) begin
        unique case (w_next)
          ST_DUT_RST: r_cnt <= PERIOD_WIDTH'(RST_CYCLES - 1);
          ST_SETTLE:  r_cnt <= r_settle - 1'b1;
          ST_MEASURE: r_cnt <= (r_measure == '0) ? '0 : r_measure - 1'b1;
          default:    r_cnt <= r_cnt;
        endcase
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (r_state == ST_IDLE && w_next == ST_DUT_RST) begin
        r_period  <= bus.period_start;
        r_step    <= bus.period_step;
        r_stop    <= bus.period_stop;
        r_settle  <= bus.settle_cycles;
        r_measure <= bus.measure_cycles;
      end else if (r_state == ST_NEXT && w_next == ST_DUT_RST) begin
        r_period <= w_sum[PERIOD_WIDTH-1:0];
      end

      if (r_state == ST_MEASURE && w_next == ST_REPORT) begin
        r_res_period <= r_period;
        r_res_count  <= w_trk_count;
        if (w_trk_count == '0) begin
          r_res_max <= '0;
          r_res_min <= '0;
          r_res_p2p <= '0;
        end else begin
          r_res_max <= w_trk_max;
          r_res_min <= w_trk_min;
          r_res_p2p <= w_p2p;
        end
      end
    end
  end

  assign bus.period     = r_period;
  assign bus.dut_rst    = r_dut_rst;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_period = r_res_period;
  assign bus.res_max    = r_res_max;
  assign bus.res_min    = r_res_min;
  assign bus.res_p2p    = r_res_p2p;
  assign bus.res_count  = r_res_count;
endmodule
